vga_timing_gen: RTL and testbench

- Upstream raster-timing stage for every *_mapper sprite/tile block.
- Generates the DrawX/DrawY pixel coordinates and the active-video `blank` qualifier that mappers consume on vga_clk.
- Generates hsync/vsync for the VGA connector, delayed to line up with the mappers' two-cycle ROM + output-register pipeline.
- Default timing is 640x480 @ 60 Hz with a 25 MHz vga_clk.

---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_timing_axis.sv | 66 ++++++
 rtl/vga_timing_gen.sv | 116 +++++++++++
 tb/tb_vga_timing_gen.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared raster-timing types and default 640x480 @ 60 Hz constants.
package vga_pkg;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      FRONT  = 2'd1,
      SYNC   = 2'd2,
      BACK   = 2'd3
   } phase_t;

   localparam int unsigned CNT_W = 10;

   localparam int unsigned H_VISIBLE_DEF = 640;
   localparam int unsigned H_FRONT_DEF   = 16;
   localparam int unsigned H_SYNC_DEF    = 96;
   localparam int unsigned H_BACK_DEF    = 48;

   localparam int unsigned V_VISIBLE_DEF = 480;
   localparam int unsigned V_FRONT_DEF   = 10;
   localparam int unsigned V_SYNC_DEF    = 2;
   localparam int unsigned V_BACK_DEF    = 33;

   function automatic int unsigned axis_total(input int unsigned visible, input int unsigned front,
                                              input int unsigned sync, input int unsigned back);
      return visible + front + sync + back;
   endfunction

   function automatic int unsigned h_total(input int unsigned visible, input int unsigned front,
                                           input int unsigned sync, input int unsigned back);
      return axis_total(visible, front, sync, back);
   endfunction

   function automatic int unsigned v_total(input int unsigned visible, input int unsigned front,
                                           input int unsigned sync, input int unsigned back);
      return axis_total(visible, front, sync, back);
   endfunction

endpackage

// File: rtl/vga_timing_axis.sv
// One raster axis: wrapping counter plus ACTIVE/FRONT/SYNC/BACK phase tracker.
// Decodes are taken from the next state so a downstream register lines up with count.
module vga_timing_axis
   import vga_pkg::*;
#(
   parameter int unsigned VISIBLE = H_VISIBLE_DEF,
   parameter int unsigned FRONT   = H_FRONT_DEF,
   parameter int unsigned SYNC    = H_SYNC_DEF,
   parameter int unsigned BACK    = H_BACK_DEF,
   parameter int unsigned CW      = CNT_W
) (
   input  logic          vga_clk,
   input  logic          reset,
   input  logic          advance,
   output logic [CW-1:0] count,
   output logic [CW-1:0] next_count,
   output phase_t        phase,
   output logic          active,
   output logic          sync_n,
   output logic          wrap
);

   localparam int unsigned TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);

   localparam logic [CW-1:0] LAST_CNT  = CW'(TOTAL - 1);
   localparam logic [CW-1:0] END_ACT   = CW'(VISIBLE - 1);
   localparam logic [CW-1:0] END_FRONT = CW'(VISIBLE + FRONT - 1);
   localparam logic [CW-1:0] END_SYNC  = CW'(VISIBLE + FRONT + SYNC - 1);

   logic [CW-1:0] count_q;
   phase_t        phase_q;
   phase_t        phase_d;

   // Next count and next phase; each phase change fires one count before its boundary.
   always_comb begin
      wrap       = advance && (count_q == LAST_CNT);
      next_count = count_q;
      phase_d    = phase_q;
      if (advance) begin
         next_count = wrap ? '0 : count_q + CW'(1);
         case (phase_q)
            vga_pkg::ACTIVE: if (count_q == END_ACT)   phase_d = vga_pkg::FRONT;
            vga_pkg::FRONT:  if (count_q == END_FRONT) phase_d = vga_pkg::SYNC;
            vga_pkg::SYNC:   if (count_q == END_SYNC)  phase_d = vga_pkg::BACK;
            vga_pkg::BACK:   if (wrap)                 phase_d = vga_pkg::ACTIVE;
            default:         if (wrap)                 phase_d = vga_pkg::ACTIVE;
         endcase
      end
      active = (phase_d == vga_pkg::ACTIVE);
      sync_n = (phase_d != vga_pkg::SYNC);
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         count_q <= '0;
         phase_q <= vga_pkg::ACTIVE;
      end else begin
         count_q <= next_count;
         phase_q <= phase_d;
      end
   end

   assign count = count_q;
   assign phase = phase_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing for the sprite/tile mappers: DrawX/DrawY, blank, pulses and
// hs/vs delayed to match the mappers' two-cycle colour pipeline.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_VISIBLE  = H_VISIBLE_DEF,
   parameter int unsigned H_FRONT    = H_FRONT_DEF,
   parameter int unsigned H_SYNC     = H_SYNC_DEF,
   parameter int unsigned H_BACK     = H_BACK_DEF,
   parameter int unsigned V_VISIBLE  = V_VISIBLE_DEF,
   parameter int unsigned V_FRONT    = V_FRONT_DEF,
   parameter int unsigned V_SYNC     = V_SYNC_DEF,
   parameter int unsigned V_BACK     = V_BACK_DEF,
   parameter int unsigned SYNC_DELAY = 2,
   parameter int unsigned FC_W       = 16
) (
   input  logic             vga_clk,
   input  logic             reset,
   output logic [9:0]       DrawX,
   output logic [9:0]       DrawY,
   output logic             blank,
   output logic             hs,
   output logic             vs,
   output logic             frame_start,
   output logic             line_end,
   output logic [FC_W-1:0]  frame_count
);

   localparam int unsigned H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);

   logic             run_q;
   logic [CNT_W-1:0] h_next;
   logic [CNT_W-1:0] v_next;
   phase_t           h_phase;
   phase_t           v_phase;
   logic             h_active;
   logic             v_active;
   logic             h_sync_n;
   logic             v_sync_n;
   logic             h_wrap;
   logic             v_wrap;

   logic             blank_q;
   logic             frame_start_q;
   logic             line_end_q;
   logic [FC_W-1:0]  frame_count_q;
   logic [1:0]       sync_pipe_q [SYNC_DELAY+1];

   // run_q holds both counters at (0,0) for the first edge out of reset so that
   // pixel (0,0) is presented with blank and frame_start already asserted.
   vga_timing_axis #(
      .VISIBLE (H_VISIBLE),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK),
      .CW      (CNT_W)
   ) u_h_axis (
      .vga_clk    (vga_clk),
      .reset      (reset),
      .advance    (run_q),
      .count      (DrawX),
      .next_count (h_next),
      .phase      (h_phase),
      .active     (h_active),
      .sync_n     (h_sync_n),
      .wrap       (h_wrap)
   );

   vga_timing_axis #(
      .VISIBLE (V_VISIBLE),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK),
      .CW      (CNT_W)
   ) u_v_axis (
      .vga_clk    (vga_clk),
      .reset      (reset),
      .advance    (h_wrap),
      .count      (DrawY),
      .next_count (v_next),
      .phase      (v_phase),
      .active     (v_active),
      .sync_n     (v_sync_n),
      .wrap       (v_wrap)
   );

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         run_q         <= 1'b0;
         blank_q       <= 1'b0;
         frame_start_q <= 1'b0;
         line_end_q    <= 1'b0;
         frame_count_q <= '0;
         for (int i = 0; i <= int'(SYNC_DELAY); i++) sync_pipe_q[i] <= 2'b11;
      end else begin
         run_q         <= 1'b1;
         blank_q       <= h_active && v_active;
         frame_start_q <= (h_next == '0) && (v_next == '0);
         line_end_q    <= (h_next == CNT_W'(H_TOTAL - 1));
         if (v_wrap) frame_count_q <= frame_count_q + FC_W'(1);
         // Stage 0 is aligned with DrawX; each further stage adds one clock of lag.
         sync_pipe_q[0] <= {h_sync_n, v_sync_n};
         for (int i = 1; i <= int'(SYNC_DELAY); i++) sync_pipe_q[i] <= sync_pipe_q[i-1];
         assert ((h_phase == ACTIVE) == (DrawX < CNT_W'(H_VISIBLE)));
         assert ((v_phase == ACTIVE) == (DrawY < CNT_W'(V_VISIBLE)));
      end
   end

   assign blank       = blank_q;
   assign frame_start = frame_start_q;
   assign line_end    = line_end_q;
   assign frame_count = frame_count_q;
   assign hs          = sync_pipe_q[SYNC_DELAY][1];
   assign vs          = sync_pipe_q[SYNC_DELAY][0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: expectations are queued with their cycle stamp, a negedge monitor checks them.
// dut_a/dut_b use 640x480 timing (sync delay 0/2); dut_c uses a tiny 15x9 raster with FC_W=2.
module tb_vga_timing_gen;

   localparam int F_X = 0, F_Y = 1, F_BLANK = 2, F_HS = 3, F_VS = 4, F_FS = 5, F_LE = 6, F_FC = 7;
   localparam int SA = 0, SB = 1, SC = 2;

   typedef struct {
      int    cyc;
      int    sel;
      int    fld;
      int    val;
      string name;
   } exp_t;

   logic clk;
   logic rst_ab;
   logic rst_c;

   logic [9:0]  xa, ya, xb, yb, xc, yc;
   logic        ba, hsa, vsa, fsa, lea;
   logic        bb, hsb, vsb, fsb, leb;
   logic        bc, hsc, vsc, fsc, lec;
   logic [15:0] fca, fcb;
   logic [1:0]  fcc;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   int   act;

   vga_timing_gen #(.SYNC_DELAY(0), .FC_W(16)) dut_a (
      .vga_clk(clk), .reset(rst_ab), .DrawX(xa), .DrawY(ya), .blank(ba), .hs(hsa), .vs(vsa),
      .frame_start(fsa), .line_end(lea), .frame_count(fca)
   );

   vga_timing_gen #(.SYNC_DELAY(2), .FC_W(16)) dut_b (
      .vga_clk(clk), .reset(rst_ab), .DrawX(xb), .DrawY(yb), .blank(bb), .hs(hsb), .vs(vsb),
      .frame_start(fsb), .line_end(leb), .frame_count(fcb)
   );

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
      .SYNC_DELAY(2), .FC_W(2)
   ) dut_c (
      .vga_clk(clk), .reset(rst_c), .DrawX(xc), .DrawY(yc), .blank(bc), .hs(hsc), .vs(vsc),
      .frame_start(fsc), .line_end(lec), .frame_count(fcc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int get_field(input int sel, input int fld);
      logic [9:0] x, y;
      logic       b, h, v, f, l;
      int         fc;
      case (sel)
         SA:      begin x = xa; y = ya; b = ba; h = hsa; v = vsa; f = fsa; l = lea; fc = int'(fca); end
         SB:      begin x = xb; y = yb; b = bb; h = hsb; v = vsb; f = fsb; l = leb; fc = int'(fcb); end
         default: begin x = xc; y = yc; b = bc; h = hsc; v = vsc; f = fsc; l = lec; fc = int'(fcc); end
      endcase
      case (fld)
         F_X:     return int'(x);
         F_Y:     return int'(y);
         F_BLANK: return int'(b);
         F_HS:    return int'(h);
         F_VS:    return int'(v);
         F_FS:    return int'(f);
         F_LE:    return int'(l);
         default: return fc;
      endcase
   endfunction

   task automatic push_exp(input int c, input int sel, input int fld, input int val, input string name);
      exp_t e;
      e.cyc  = c;
      e.sel  = sel;
      e.fld  = fld;
      e.val  = val;
      e.name = name;
      sb.push_back(e);
   endtask

   // Monitor: every expectation stamped with the current cycle is checked and retired.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            act = get_field(sb[i].sel, sb[i].fld);
            checks++;
            if (act != sb[i].val) begin
               errors++;
               $display("FAIL %s (cycle %0d): got %0d, expected %0d", sb[i].name, cyc, act, sb[i].val);
            end
            sb.delete(i);
         end
      end
   end

   // Cycle stamp = posedge index; after release at edge 5 the raster index is n = cycle - 6.
   initial begin
      rst_ab = 1'b1;
      rst_c  = 1'b1;

      for (int s = 0; s < 3; s += 2) begin
         push_exp(3, s, F_X, 0, "rst.DrawX");
         push_exp(3, s, F_Y, 0, "rst.DrawY");
         push_exp(3, s, F_BLANK, 0, "rst.blank");
         push_exp(3, s, F_HS, 1, "rst.hs");
         push_exp(3, s, F_VS, 1, "rst.vs");
         push_exp(3, s, F_FC, 0, "rst.frame_count");
         push_exp(3, s, F_FS, 0, "rst.frame_start");
      end
      push_exp(6, SA, F_X, 0, "a.first.DrawX");
      push_exp(6, SA, F_Y, 0, "a.first.DrawY");
      push_exp(6, SA, F_BLANK, 1, "a.first.blank");
      push_exp(6, SA, F_FS, 1, "a.first.frame_start");
      push_exp(6, SA, F_HS, 1, "a.first.hs");
      push_exp(6, SC, F_X, 0, "c.first.DrawX");
      push_exp(6, SC, F_BLANK, 1, "c.first.blank");
      push_exp(6, SC, F_FS, 1, "c.first.frame_start");
      push_exp(7, SA, F_X, 1, "a.second.DrawX");
      push_exp(7, SA, F_FS, 0, "a.second.frame_start");

      push_exp(645, SA, F_BLANK, 1, "a.blank@639");
      push_exp(646, SA, F_BLANK, 0, "a.blank@640");
      push_exp(646, SA, F_X, 640, "a.DrawX@640");
      push_exp(661, SA, F_HS, 1, "a.hs@655");
      push_exp(662, SA, F_HS, 0, "a.hs@656");
      push_exp(757, SA, F_HS, 0, "a.hs@751");
      push_exp(758, SA, F_HS, 1, "a.hs@752");
      push_exp(663, SB, F_HS, 1, "b.hs@657");
      push_exp(664, SB, F_HS, 0, "b.hs@658");
      push_exp(664, SB, F_X, 658, "b.DrawX@658");
      push_exp(759, SB, F_HS, 0, "b.hs@753");
      push_exp(760, SB, F_HS, 1, "b.hs@754");
      push_exp(804, SA, F_LE, 0, "a.line_end@798");
      push_exp(805, SA, F_LE, 1, "a.line_end@799");
      push_exp(805, SA, F_X, 799, "a.DrawX@799");
      push_exp(806, SA, F_X, 0, "a.wrap.DrawX");
      push_exp(806, SA, F_Y, 1, "a.wrap.DrawY");
      push_exp(806, SA, F_LE, 0, "a.wrap.line_end");
      push_exp(806, SA, F_BLANK, 1, "a.wrap.blank");

      push_exp(17, SC, F_HS, 1, "c.hs@x11");
      push_exp(18, SC, F_HS, 0, "c.hs@x12");
      push_exp(20, SC, F_HS, 0, "c.hs@x14");
      push_exp(21, SC, F_HS, 1, "c.hs@x0y1");
      push_exp(21, SC, F_Y, 1, "c.DrawY@n15");
      push_exp(58, SC, F_BLANK, 1, "c.blank@x7y3");
      push_exp(59, SC, F_BLANK, 0, "c.blank@x8y3");
      push_exp(66, SC, F_BLANK, 0, "c.blank@x0y4");
      push_exp(82, SC, F_VS, 1, "c.vs@x1y5");
      push_exp(83, SC, F_VS, 0, "c.vs@x2y5");
      push_exp(83, SC, F_X, 2, "c.DrawX@n77");
      push_exp(83, SC, F_Y, 5, "c.DrawY@n77");
      push_exp(112, SC, F_VS, 0, "c.vs@x1y7");
      push_exp(113, SC, F_VS, 1, "c.vs@x2y7");

      push_exp(140, SC, F_X, 14, "c.f1.pre.DrawX");
      push_exp(140, SC, F_Y, 8, "c.f1.pre.DrawY");
      push_exp(140, SC, F_FC, 0, "c.f1.pre.frame_count");
      push_exp(141, SC, F_X, 0, "c.f1.DrawX");
      push_exp(141, SC, F_Y, 0, "c.f1.DrawY");
      push_exp(141, SC, F_FS, 1, "c.f1.frame_start");
      push_exp(141, SC, F_FC, 1, "c.f1.frame_count");
      push_exp(276, SC, F_FC, 2, "c.f2.frame_count");
      push_exp(411, SC, F_FC, 3, "c.f3.frame_count");
      push_exp(545, SC, F_FC, 3, "c.f4.pre.frame_count");
      push_exp(546, SC, F_FC, 0, "c.f4.frame_count");
      push_exp(681, SC, F_FC, 1, "c.f5.frame_count");
      push_exp(681, SC, F_FS, 1, "c.f5.frame_start");

      push_exp(724, SC, F_X, 13, "c.prerst.DrawX");
      push_exp(724, SC, F_Y, 2, "c.prerst.DrawY");
      push_exp(724, SC, F_HS, 0, "c.prerst.hs");
      push_exp(724, SC, F_FC, 1, "c.prerst.frame_count");
      push_exp(725, SC, F_X, 0, "c.midrst.DrawX");
      push_exp(725, SC, F_Y, 0, "c.midrst.DrawY");
      push_exp(725, SC, F_HS, 1, "c.midrst.hs");
      push_exp(725, SC, F_FC, 0, "c.midrst.frame_count");
      push_exp(725, SC, F_BLANK, 0, "c.midrst.blank");
      push_exp(725, SC, F_FS, 0, "c.midrst.frame_start");
      push_exp(727, SC, F_X, 0, "c.rerun.DrawX");
      push_exp(727, SC, F_BLANK, 1, "c.rerun.blank");
      push_exp(727, SC, F_FS, 1, "c.rerun.frame_start");
      push_exp(727, SC, F_HS, 1, "c.rerun.hs");
      push_exp(728, SC, F_X, 1, "c.rerun2.DrawX");
      push_exp(728, SC, F_FS, 0, "c.rerun2.frame_start");

      while (cyc < 5) begin @(posedge clk); #1; end
      checks++;
      if (xa != 10'd0 || ya != 10'd0) begin
         errors++;
         $display("FAIL direct.rst.a.counters: got (%0d,%0d), expected (0,0)", xa, ya);
      end
      checks++;
      if (ba != 1'b0) begin
         errors++;
         $display("FAIL direct.rst.a.blank: got %0d, expected 0", ba);
      end
      checks++;
      if (hsa != 1'b1 || vsa != 1'b1) begin
         errors++;
         $display("FAIL direct.rst.a.sync: got hs=%0d vs=%0d, expected 1/1", hsa, vsa);
      end
      checks++;
      if (fca != 16'd0) begin
         errors++;
         $display("FAIL direct.rst.a.frame_count: got %0d, expected 0", fca);
      end
      rst_ab = 1'b0;
      rst_c  = 1'b0;

      while (cyc < 724) begin @(posedge clk); #1; end
      rst_c = 1'b1;
      while (cyc < 726) begin @(posedge clk); #1; end
      rst_c = 1'b0;

      while (cyc < 812) begin @(posedge clk); #1; end
      checks++;
      if (xa != 10'd6) begin
         errors++;
         $display("FAIL direct.a.DrawX@812: got %0d, expected 6", xa);
      end
      checks++;
      if (ya != 10'd1) begin
         errors++;
         $display("FAIL direct.a.DrawY@812: got %0d, expected 1", ya);
      end
      checks++;
      if (ba != 1'b1) begin
         errors++;
         $display("FAIL direct.a.blank@812: got %0d, expected 1", ba);
      end
      checks++;
      if (xb != 10'd6 || yb != 10'd1) begin
         errors++;
         $display("FAIL direct.b.counters@812: got (%0d,%0d), expected (6,1)", xb, yb);
      end
      checks++;
      if (hsb != 1'b1) begin
         errors++;
         $display("FAIL direct.b.hs@812: got %0d, expected 1", hsb);
      end
      checks++;
      if (fsb != 1'b0) begin
         errors++;
         $display("FAIL direct.b.frame_start@812: got %0d, expected 0", fsb);
      end
      checks++;
      if (fca != 16'd0) begin
         errors++;
         $display("FAIL direct.a.frame_count@812: got %0d, expected 0", fca);
      end
      @(negedge clk);
      #1;
      foreach (sb[i]) begin
         checks++;
         errors++;
         $display("FAIL %s: never sampled, expected %0d at cycle %0d", sb[i].name, sb[i].val, sb[i].cyc);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
